shift_seq16: RTL and testbench
==============================

Name: shift_seq16

Overview:
Iterative 16-bit shift/rotate sequencer for the ALU shifter path. It sits directly upstream of the registered rotate stage and the ALU result mux. It accepts one request (op, operand, amount) over a valid/ready handshake and shifts by one bit per clock. It then presents the result, carry-out and zero flag with a one-cycle done pulse. It covers LSL, LSR, ASR, ROL and ROR, so the datapath needs no barrel shifter for every op.

Parameters:
WIDTH, 16, operand/result width
SHW, 4, shift-amount width (amount range 0..2^SHW-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
op  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 illegal
operand  in  WIDTH  data to shift
amount  in  SHW  number of bit positions
result  out  WIDTH  shifted data, valid when done=1, held until next accept
carry  out  1  last bit shifted or rotated out
zero  out  1  result==0
done  out  1  one-cycle pulse, result/flags valid
busy  out  1  operation in progress (state SHIFT)
err  out  1  illegal op flagged with done

Behaviour:
- Reset: on clk edge with rst=1 go to IDLE. result=0, carry=0, zero=0, done=0, busy=0, err=0, internal counter=0.
- rst mid-operation discards the in-flight request; no done is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) || (state==DONE). This allows back-to-back requests.
- Accept occurs on an edge where in_valid && in_ready:
  - Latch operand into the data register and op into the op register; load cnt=amount; clear carry.
  - If amount==0 or op is illegal, go to DONE. Otherwise go to SHIFT.
- Each SHIFT edge:
  - Apply a one-bit step to data; carry gets the bit shifted out; cnt decrements.
  - When cnt==1 before the decrement, go to DONE.
- Step rules:
  - LSL: data={data[14:0],0}, carry=data[15].
  - LSR: data={0,data[15:1]}, carry=data[0].
  - ASR: data={data[15],data[15:1]}, carry=data[0].
  - ROL: data={data[14:0],data[15]}, carry=data[15].
  - ROR: data={data[0],data[15:1]}, carry=data[0].
- DONE lasts one cycle: done=1, err=1 if op was illegal.
  - From DONE go to SHIFT or DONE if a new request is accepted that edge, else to IDLE.
- Latency: done is high in cycle n+1 after the accept cycle, where n=amount. For amount 0 or an illegal op, done is high in cycle 1.
- amount==0: result=operand, carry=0.
- Illegal op: result=operand, carry=0, err=1.
- in_valid while busy is ignored (in_ready=0). The requester must hold its request.
- result, carry and zero hold after done until the next accept. zero is computed on the final data value.
- Rotate results match the registered rotate stage, e.g. ROL 0x800B by 4 gives 0x00B8.
- No wrap beyond 15: the maximum amount is 15, so cnt never underflows.

Decomposition:
- Package shift_pkg holds:
  - op encodings OP_LSL..OP_ROR
  - the state enum {IDLE, SHIFT, DONE}
  - WIDTH/SHW defaults
- One combinational sub-module, shift1_step, takes (op, data) and returns (next_data, out_bit).
- The FSM, counter and handshake live in shift_seq16.

Test Plan:
- Reset, then ROL operand=0x800B amount=4 -> done in cycle 5 after accept; result=0x00B8, carry=0, zero=0, busy high cycles 1-4.
- LSR 0x000B by 2 -> result=0x0002, carry=1. ASR 0x8000 by 3 -> result=0xF000, carry=0.
- LSL 0x8000 by 1 -> result=0x0000, carry=1, zero=1. ROR 0x0001 by 1 -> result=0x8000, carry=1.
- amount=0 with operand=0x1234 -> done in cycle 1, result=0x1234, carry=0. op=111 -> done cycle 1, err=1, result=operand.
- Back-to-back: second request held valid during DONE is accepted that edge. in_valid during SHIFT is not accepted (in_ready=0). Result holds between requests.
- rst asserted during SHIFT of LSL 0xFFFF by 15 -> next edge: IDLE, all outputs 0, no done pulse. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift/rotate sequencer: op encodings,
// FSM states and default widths.
package shift_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SHW   = 4;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/shift_seq16_shift1_step.sv
// One-bit shift/rotate step: returns the next data word and the bit moved out.
module shift1_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] next_data,
  output logic             out_bit
);

  // Illegal ops pass data through untouched with no carry.
  always_comb begin
    next_data = data;
    out_bit   = 1'b0;
    case (op)
      OP_LSL: begin
        next_data = {data[WIDTH-2:0], 1'b0};
        out_bit   = data[WIDTH-1];
      end
      OP_LSR: begin
        next_data = {1'b0, data[WIDTH-1:1]};
        out_bit   = data[0];
      end
      OP_ASR: begin
        next_data = {data[WIDTH-1], data[WIDTH-1:1]};
        out_bit   = data[0];
      end
      OP_ROL: begin
        next_data = {data[WIDTH-2:0], data[WIDTH-1]};
        out_bit   = data[WIDTH-1];
      end
      OP_ROR: begin
        next_data = {data[0], data[WIDTH-1:1]};
        out_bit   = data[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_seq16.sv
// Iterative shift/rotate sequencer: one bit per clock, valid/ready request,
// one-cycle done pulse with result, carry, zero and illegal-op error.
module shift_seq16
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             done,
  output logic             busy,
  output logic             err
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       op_q;
  logic [SHW-1:0]   cnt;
  logic             carry_q;
  logic             zero_q;
  logic             accept;
  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  shift1_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_q),
    .data      (data_q),
    .next_data (step_data),
    .out_bit   (step_bit)
  );

  assign in_ready = (state == IDLE) || (state == DONE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_nxt = ((amount == '0) || !op_legal(op)) ? DONE : SHIFT;
        else
          state_nxt = IDLE;
      end
      SHIFT:   state_nxt = (cnt == CNT_ONE) ? DONE : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath is also cleared on reset so outputs read zero after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      op_q    <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_q  <= operand;
        op_q    <= op;
        cnt     <= amount;
        carry_q <= 1'b0;
        zero_q  <= (operand == '0);
      end else if (state == SHIFT) begin
        data_q  <= step_data;
        carry_q <= step_bit;
        cnt     <= cnt - CNT_ONE;
        zero_q  <= (step_data == '0);
      end
    end
  end

  assign result = data_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign done   = (state == DONE);
  assign busy   = (state == SHIFT);
  assign err    = (state == DONE) && !op_legal(op_q);

endmodule

// File: tb/tb_shift_seq16.sv
// Directed bench for shift_seq16: vector table plus back-to-back and reset
// corner sequences.
module tb_shift_seq16;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] operand;
  logic [3:0]  amount;
  logic [15:0] result;
  logic        carry, zero, done, busy, err;

  int checks = 0;
  int errors = 0;

  shift_seq16 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .operand  (operand),
    .amount   (amount),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] opnd;
    logic [3:0]  amt;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        e;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1 of the cycle after accept; returns cycles to done.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_flags"}, {27'd0, carry, zero, done, busy, err}, 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat, bc, exp_lat, done_seen;

    vecs[0]  = '{OP_ROL, 16'h800B, 4'd4,  16'h00B8, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_LSR, 16'h000B, 4'd2,  16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{OP_ASR, 16'h8000, 4'd3,  16'hF000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_LSL, 16'h8000, 4'd1,  16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{OP_ROR, 16'h0001, 4'd1,  16'h8000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{OP_LSL, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b111, 16'h5A5A, 4'd3,  16'h5A5A, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{OP_LSL, 16'hFFFF, 4'd15, 16'h8000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{OP_ROR, 16'h1234, 4'd15, 16'h2468, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_ASR, 16'h7FFF, 4'd15, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{OP_LSR, 16'hFFFF, 4'd4,  16'h0FFF, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'b101, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; op = '0; operand = '0; amount = '0;
    step(3);
    rst = 1'b0;
    check_idle_outputs("reset");

    // Table-driven requests; each new one is offered during the previous DONE.
    for (int i = 0; i < 12; i++) begin
      op = vecs[i].op; operand = vecs[i].opnd; amount = vecs[i].amt;
      in_valid = 1'b1;
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(lat, bc);
      exp_lat = ((vecs[i].amt == 0) || (vecs[i].op > OP_ROR)) ? 1 : vecs[i].amt + 1;
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(exp_lat - 1));
      chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("v%0d_carry", i), 32'(carry), 32'(vecs[i].c));
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e));
    end

    // Hold after done: no pulse, result and flags unchanged.
    step(3);
    chk("hold_done", 32'(done), 32'd0);
    chk("hold_result", 32'(result), 32'h0000);
    chk("hold_zero", 32'(zero), 32'd1);

    // Request offered during SHIFT must wait; taken on the DONE edge.
    op = OP_LSR; operand = 16'h000B; amount = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    op = OP_LSL; operand = 16'h8000; amount = 4'd1;
    chk("b2b_not_ready_in_shift", 32'(in_ready), 32'd0);
    wait_done(lat, bc);
    chk("b2b_a_latency", 32'(lat), 32'd3);
    chk("b2b_a_result", 32'(result), 32'h0002);
    chk("b2b_a_carry", 32'(carry), 32'd1);
    chk("b2b_ready_in_done", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_b_busy", 32'(busy), 32'd1);
    wait_done(lat, bc);
    chk("b2b_b_latency", 32'(lat), 32'd2);
    chk("b2b_b_result", 32'(result), 32'h0000);
    chk("b2b_b_carry_zero", {30'd0, carry, zero}, 32'd3);

    // Reset mid-operation discards the request with no done pulse.
    op = OP_LSL; operand = 16'hFFFF; amount = 4'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    step(3);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("rst_mid");
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    chk("rst_mid_no_done", 32'(done_seen), 32'd0);

    // Fresh request after the abort.
    op = OP_ROL; operand = 16'h800B; amount = 4'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat, bc);
    chk("post_rst_latency", 32'(lat), 32'd5);
    chk("post_rst_result", 32'(result), 32'h00B8);
    chk("post_rst_carry_err", {30'd0, carry, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
